// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   owner_e        : which port owns the read response that is due next cycle
//   DEF_ADDR_W     : default BRAM doubleword-address width
//   DEF_MAX_IF_WAIT: default number of denied fetch cycles before fetch is forced to win
//   cnt_width()    : width of a counter that has to hold 0..max_val
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

   localparam int DEF_ADDR_W      = 13;
   localparam int DEF_MAX_IF_WAIT = 4;

   // A counter is never narrower than one bit, even when max_val is 0.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: every bus signal around the arbiter.
//   fetch port : i_req, i_addr, i_flush -> i_gnt, i_rvalid, i_rdata
//   data port  : d_req, d_we, d_wstrb, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   BRAM port  : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (1-cycle latency)
//   stalls     : stall_if, stall_mem
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);
   logic              i_req;
   logic [63:0]       i_addr;
   logic              i_flush;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;

   logic              d_req;
   logic              d_we;
   logic [7:0]        d_wstrb;
   logic [63:0]       d_addr;
   logic [63:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [63:0]       d_rdata;

   logic              mem_en;
   logic [7:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;

   logic              stall_if;
   logic              stall_mem;

   modport master (
      output i_req, i_addr, i_flush, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );

   modport slave (
      input  i_req, i_addr, i_flush, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// arb_wait_counter: counts consecutive cycles in which fetch asked and was refused.
//   clk, reset : clock and synchronous active-high reset
//   i_req      : fetch request this cycle
//   i_gnt      : fetch grant this cycle
//   wait_cnt   : current count, saturating at MAX_IF_WAIT
//   force_if   : count has saturated, so fetch must win this cycle
module arb_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int MAX_IF_WAIT = DEF_MAX_IF_WAIT,
   parameter int CNT_W       = cnt_width(MAX_IF_WAIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic             i_gnt,
   output logic [CNT_W-1:0] wait_cnt,
   output logic             force_if
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_WAIT);

   logic [CNT_W-1:0] wait_cnt_q;
   logic [CNT_W-1:0] wait_cnt_d;

   always_comb begin
      wait_cnt_d = '0;
      if (i_req && !i_gnt) begin
         wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign wait_cnt = wait_cnt_q;
   assign force_if = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port BRAM between an instruction-fetch
// port and a data port. Arbitration is combinational in the request cycle;
// the read response comes back one cycle later and is steered to its owner.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave carrying fetch, data, BRAM and stall signals
// Data has priority over fetch, except that a fetch refused MAX_IF_WAIT cycles
// in a row wins the next contested cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int MAX_IF_WAIT = DEF_MAX_IF_WAIT
) (
   input  logic           clk,
   input  logic           reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = cnt_width(MAX_IF_WAIT);

   logic             i_gnt;
   logic             d_gnt;
   logic             force_if;
   logic [CNT_W-1:0] wait_cnt;

   owner_e           owner_q;
   owner_e           owner_d;
   logic             half_q;
   logic             half_d;

   logic              mem_en;
   logic [7:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;

   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_rvalid;
   logic [63:0]       d_rdata;

   arb_wait_counter #(
      .MAX_IF_WAIT (MAX_IF_WAIT),
      .CNT_W       (CNT_W)
   ) u_wait (
      .clk      (clk),
      .reset    (reset),
      .i_req    (bus.i_req),
      .i_gnt    (i_gnt),
      .wait_cnt (wait_cnt),
      .force_if (force_if)
   );

   // Grants are held low during reset so nothing reaches the BRAM.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (bus.i_req && (force_if || !bus.d_req)) begin
            i_gnt = 1'b1;
         end else if (bus.d_req) begin
            d_gnt = 1'b1;
         end
      end
   end

   // BRAM command: the word address drops the byte offset and any bits above the array.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_en   = 1'b1;
         mem_addr = bus.d_addr[ADDR_W+2:3];
         if (bus.d_we) begin
            mem_we    = bus.d_wstrb;
            mem_wdata = bus.d_wdata;
         end
      end else if (i_gnt) begin
         mem_en   = 1'b1;
         mem_addr = bus.i_addr[ADDR_W+2:3];
      end
   end

   // Remember who gets next cycle's BRAM data. Writes finish in the grant cycle.
   always_comb begin
      owner_d = OWN_NONE;
      half_d  = 1'b0;
      if (d_gnt && !bus.d_we) begin
         owner_d = OWN_DATA;
      end else if (i_gnt) begin
         owner_d = OWN_IF;
         half_d  = bus.i_addr[2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_NONE;
         half_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         half_q  <= half_d;
      end
   end

   // Response steering. Gating with reset drops a read that was in flight when
   // reset arrived; i_flush drops only the fetch response due this cycle.
   always_comb begin
      i_rvalid = 1'b0;
      i_rdata  = '0;
      d_rvalid = 1'b0;
      d_rdata  = '0;
      if (!reset) begin
         if (owner_q == OWN_DATA) begin
            d_rvalid = 1'b1;
            d_rdata  = bus.mem_rdata;
         end
         if (owner_q == OWN_IF && !bus.i_flush) begin
            i_rvalid = 1'b1;
            i_rdata  = half_q ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
         end
      end
   end

   assign bus.i_gnt     = i_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.i_rvalid  = i_rvalid;
   assign bus.i_rdata   = i_rdata;
   assign bus.d_rvalid  = d_rvalid;
   assign bus.d_rdata   = d_rdata;
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.stall_if  = bus.i_req & ~i_gnt & ~reset;
   assign bus.stall_mem = bus.d_req & ~d_gnt & ~reset;

   // Address bits outside the word index carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_addr[63:ADDR_W+3], bus.i_addr[1:0],
                               bus.d_addr[63:ADDR_W+3], bus.d_addr[2:0], wait_cnt};

endmodule
